// File: rtl/fofir_pkg.sv
// ============================================================================
//  Module   : fofir_pkg
//  Brief    : Shared constants and helpers for the FoFIR PE tap-select path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fofir_pkg;

   localparam logic MUX_MODE_DIRECT = 1'b0;
   localparam logic MUX_MODE_SEQ    = 1'b1;

   // Index width that never collapses to zero bits for tiny tap counts.
   function automatic int clog2_min1(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fofir_seq_counter.sv
// ============================================================================
//  Module   : fofir_seq_counter
//  Brief    : Wrapping tap-index counter with start restart and length clamp.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fofir_seq_counter
   import fofir_pkg::*;
#(
   parameter int NUM_IN = 5,
   parameter int SEL_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             en,
   input  logic [SEL_W-1:0] seq_len,
   output logic [SEL_W-1:0] cur_idx,
   output logic             is_last,
   output logic             len_err
);

   localparam logic [SEL_W:0]   c_num_in  = (SEL_W+1)'(NUM_IN);
   localparam logic [SEL_W-1:0] c_max_idx = SEL_W'(NUM_IN - 1);

   logic [SEL_W-1:0] r_seq_idx;
   logic [SEL_W-1:0] w_last_idx;

   assign len_err    = {1'b0, seq_len} > c_num_in;
   assign w_last_idx = (seq_len == '0 || len_err) ? c_max_idx : seq_len - SEL_W'(1);

   // A start pulse redirects the word accepted in the same cycle to index 0.
   assign cur_idx = start ? '0 : r_seq_idx;
   assign is_last = (cur_idx == w_last_idx);

   // ">=" rather than "==" so a stale index left by a shortened length still wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq_idx <= '0;
      end else if (en) begin
         r_seq_idx <= (cur_idx >= w_last_idx) ? '0 : cur_idx + SEL_W'(1);
      end else if (start) begin
         r_seq_idx <= '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fofir_tap_mux_seq.sv
// ============================================================================
//  Module   : fofir_tap_mux_seq
//  Brief    : Registered N-input tap selector with valid/ready and auto-sequence.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fofir_tap_mux_seq
   import fofir_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_IN     = 5,
   localparam int SEL_W      = clog2_min1(NUM_IN)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_flat,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         mode,
   input  logic [SEL_W-1:0]             sel,
   input  logic [SEL_W-1:0]             seq_len,
   input  logic                         start,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SEL_W-1:0]             out_idx,
   output logic                         seq_last,
   output logic                         sel_err
);

   localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

   logic                  w_xfer;
   logic                  w_seq_mode;
   logic                  w_seq_en;
   logic [SEL_W-1:0]      w_seq_idx;
   logic                  w_is_last;
   logic                  w_len_err;
   logic [SEL_W-1:0]      w_idx;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_tap;

   assign in_ready   = !out_valid || out_ready;
   assign w_xfer     = in_valid && in_ready;
   assign w_seq_mode = (mode == MUX_MODE_SEQ);
   assign w_seq_en   = w_xfer && w_seq_mode;

   fofir_seq_counter #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_seq_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .en      (w_seq_en),
      .seq_len (seq_len),
      .cur_idx (w_seq_idx),
      .is_last (w_is_last),
      .len_err (w_len_err)
   );

   assign w_idx = w_seq_mode ? w_seq_idx : sel;
   assign w_err = ({1'b0, w_idx} >= c_num_in) || (w_seq_mode && w_len_err);

   // Out-of-range indices match no tap and fall through to zero.
   always_comb begin
      w_tap = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (w_idx == SEL_W'(k)) begin
            w_tap = in_flat[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         seq_last  <= 1'b0;
      end else if (w_xfer) begin
         out_valid <= 1'b1;
         out_data  <= w_tap;
         out_idx   <= w_idx;
         seq_last  <= w_seq_mode && w_is_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Setting wins over the start-driven clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (w_xfer && w_err) begin
         sel_err <= 1'b1;
      end else if (start) begin
         sel_err <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fofir_tap_mux_seq.sv
// ============================================================================
//  Module   : tb_fofir_tap_mux_seq
//  Brief    : Self-checking bench for fofir_tap_mux_seq against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fofir_tap_mux_seq;

   localparam int DW = 16;
   localparam int N  = 5;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N*DW-1:0] in_flat;
   logic          in_valid;
   logic          in_ready;
   logic          mode;
   logic [SW-1:0] sel;
   logic [SW-1:0] seq_len;
   logic          start;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_idx;
   logic          seq_last;
   logic          sel_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state
   logic          m_ov, m_last, m_err;
   logic [DW-1:0] m_data;
   int            m_idx, m_seq;

   always #5 clk = ~clk;

   fofir_tap_mux_seq #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .seq_len(seq_len),
      .start(start), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_idx(out_idx), .seq_last(seq_last),
      .sel_err(sel_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_ov = 1'b0; m_last = 1'b0; m_err = 1'b0; m_data = '0; m_idx = 0; m_seq = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, m_ov});
      chk({tag, ".out_data"},  {16'd0, out_data},  {16'd0, m_data});
      chk({tag, ".out_idx"},   {29'd0, out_idx},   m_idx);
      chk({tag, ".seq_last"},  {31'd0, seq_last},  {31'd0, m_last});
      chk({tag, ".sel_err"},   {31'd0, sel_err},   {31'd0, m_err});
   endtask

   // One clock: drive inputs, predict from the rules, compare after the edge.
   task automatic step(input string tag, input logic v, input logic r, input logic md,
                       input logic st, input int sl, input int sq);
      logic exp_rdy, xfer;
      int   eff, idx;
      @(negedge clk);
      in_valid = v; out_ready = r; mode = md; start = st;
      seq_len = SW'(sl); sel = SW'(sq);
      #1;
      exp_rdy = !m_ov || r;
      chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
      xfer = v && exp_rdy;
      if (xfer) begin
         eff    = (sl == 0 || sl > N) ? N : sl;
         idx    = md ? (st ? 0 : m_seq) : sq;
         m_ov   = 1'b1;
         m_idx  = idx;
         m_data = (idx < N) ? in_flat[idx*DW +: DW] : '0;
         m_last = md && (idx == eff - 1);
         if (md)      m_seq = (idx + 1 >= eff) ? 0 : idx + 1;
         else if (st) m_seq = 0;
         if (idx >= N || (md && sl > N)) m_err = 1'b1;
         else if (st)                    m_err = 1'b0;
      end else begin
         if (r) m_ov = 1'b0;
         if (st) begin m_seq = 0; m_err = 1'b0; end
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int exp_seq3[7];
      exp_seq3 = '{0, 1, 2, 0, 1, 2, 0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
      sel = '0; seq_len = '0; start = 1'b0;
      for (int k = 0; k < N; k++) in_flat[k*DW +: DW] = DW'(16'h0011 * (k + 1));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Direct select, in range and out of range
      step("dir_sel3", 1, 1, 0, 0, 0, 3);
      chk("dir_sel3.data_const", {16'd0, out_data}, 32'h0044);
      step("dir_sel6", 1, 1, 0, 0, 0, 6);
      chk("dir_sel6.err_const", {31'd0, sel_err}, 32'd1);
      step("dir_idle", 0, 1, 0, 0, 0, 0);
      step("dir_start_clr", 0, 1, 0, 1, 0, 0);
      chk("dir_start_clr.err_const", {31'd0, sel_err}, 32'd0);

      // Auto sequence, length 3, start coincident with first word
      for (int i = 0; i < 7; i++) begin
         step("seq3", 1, 1, 1, (i == 0), 3, 0);
         chk("seq3.idx_const",  {29'd0, out_idx}, exp_seq3[i]);
         chk("seq3.last_const", {31'd0, seq_last}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
      end

      // Full-length auto sequence with downstream stalls
      step("seq0_start", 0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step("seq0_stall", 1, (i % 4 == 0 || i % 4 == 3), 1, 0, 0, 0);
      end

      // Restart mid-sequence
      step("mid_start0", 0, 1, 1, 1, 4, 0);
      step("mid_w0", 1, 1, 1, 0, 4, 0);
      step("mid_w1", 1, 1, 1, 0, 4, 0);
      step("mid_restart", 1, 1, 1, 1, 4, 0);
      chk("mid_restart.idx_const", {29'd0, out_idx}, 32'd0);
      step("mid_next", 1, 1, 1, 0, 4, 0);
      chk("mid_next.idx_const", {29'd0, out_idx}, 32'd1);

      // Oversized seq_len clamps and flags
      step("len_over_start", 0, 1, 1, 1, 7, 0);
      for (int i = 0; i < 6; i++) step("len_over", 1, 1, 1, 0, 7, 0);

      // Randomised traffic
      begin
         logic md, st;
         int   sl;
         md = 1'b1; sl = 3;
         for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) in_flat[k*DW +: DW] = DW'($urandom);
            st = ($urandom_range(0, 7) == 0);
            if (st) sl = $urandom_range(0, 7);
            if ($urandom_range(0, 15) == 0) md = ~md;
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 md, st, sl, $urandom_range(0, 7));
         end
      end

      // Asynchronous reset while a word is stalled
      step("ar_seq", 1, 1, 1, 1, 3, 0);
      step("ar_err", 1, 1, 0, 0, 3, 6);
      step("ar_hold", 0, 0, 0, 0, 3, 0);
      chk("ar_hold.valid_const", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1, 1, 1, 0, 3, 0);
      chk("post_rst.idx_const", {29'd0, out_idx}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
